ld_up_counter: RTL



---
 rtl/ld_up_counter_pkg.sv | 16 +
 rtl/ld_up_counter_lscntelu.sv | 36 +++
 rtl/ld_up_counter.sv | 86 ++++++++
 3 files changed

// File: rtl/ld_up_counter_pkg.sv
// rtl/ld_up_counter_pkg.sv - shared counter constants and helpers
//
// Purpose: constants shared by the position/timer counter blocks.
//   HCNT_W / VCNT_W : widths of the horizontal and vertical position counters
//   all_ones(w)     : terminal (all-ones) count for a w-bit counter, w <= 32
package ld_up_counter_pkg;

  localparam int HCNT_W = 9;
  localparam int VCNT_W = 9;

  function automatic logic [31:0] all_ones(input int unsigned w);
    if (w >= 32) return '1;
    return (32'd1 << w) - 32'd1;
  endfunction

endpackage

// File: rtl/ld_up_counter_lscntelu.sv
// rtl/ld_up_counter_lscntelu.sv - one-bit loadable up-count element
//
// Purpose: one stage of the ripple up-counter (toggle on carry, load mux, reset flop).
// Ports:
//   CLK  : clock, rising edge
//   RSTL : asynchronous active-low reset, clears Q
//   D    : load value for this bit
//   LD   : synchronous load, active-high, wins over counting
//   CI   : carry in from the lower stage, active-high
//   Q    : bit value
//   QL   : complement of Q
//   CO   : carry out to the next stage, CI & Q
module lscntelu (
  input  logic CLK,
  input  logic RSTL,
  input  logic D,
  input  logic LD,
  input  logic CI,
  output logic Q,
  output logic QL,
  output logic CO
);

  always_ff @(posedge CLK or negedge RSTL) begin
    if (!RSTL) begin
      Q <= 1'b0;
    end else begin
      Q <= LD ? D : (Q ^ CI);
    end
  end

  // Carry is active-high: this stage passes the carry only when it is a 1.
  assign CO = CI & Q;
  assign QL = ~Q;

endmodule

// File: rtl/ld_up_counter.sv
// rtl/ld_up_counter.sv - loadable synchronous up counter with TC pulse and sticky overflow
//
// Purpose: WIDTH-bit ripple-carry up counter built from lscntelu elements.
// Parameters:
//   WIDTH  : counter width (>= 2)
//   AUTOLD : 1 = reload from D on wrap, 0 = roll over to zero
// Ports:
//   CLK    : clock, rising edge
//   RSTL   : asynchronous active-low reset
//   D      : load value
//   LD     : synchronous load, active-high
//   CI     : count enable / carry in
//   CLROVF : synchronous clear of OVF
//   Q, QL  : count value and its complement
//   CO     : combinational carry out, CI & (Q == all-ones)
//   TC     : registered terminal-count pulse
//   OVF    : sticky overflow flag
module ld_up_counter
  import ld_up_counter_pkg::*;
#(
  parameter int WIDTH  = HCNT_W,
  parameter int AUTOLD = 0
) (
  input  logic             CLK,
  input  logic             RSTL,
  input  logic [WIDTH-1:0] D,
  input  logic             LD,
  input  logic             CI,
  input  logic             CLROVF,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] QL,
  output logic             CO,
  output logic             TC,
  output logic             OVF
);

  localparam bit RELOAD_D = (AUTOLD != 0);

  logic ld_eff;
  logic wrap;

  // Each stage holds its own carry net so the ripple is a chain of distinct
  // signals rather than one vector feeding back into itself.
  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    logic cin;
    logic cout;
    if (i == 0) begin : g_first
      assign cin = CI;
    end else begin : g_next
      assign cin = g_bit[i-1].cout;
    end
    lscntelu u_el (
      .CLK  (CLK),
      .RSTL (RSTL),
      .D    (D[i]),
      .LD   (ld_eff),
      .CI   (cin),
      .Q    (Q[i]),
      .QL   (QL[i]),
      .CO   (cout)
    );
  end

  assign CO   = g_bit[WIDTH-1].cout;
  assign wrap = CO & ~LD;

  // In reload mode the wrap edge turns into a load of D in every element,
  // so D is sampled on that edge instead of the counter rolling to zero.
  assign ld_eff = LD | (RELOAD_D & CO);

  always_ff @(posedge CLK or negedge RSTL) begin
    if (!RSTL) begin
      TC  <= 1'b0;
      OVF <= 1'b0;
    end else begin
      TC <= wrap;
      // Setting has priority over clearing so a wrap is never lost.
      if (wrap) begin
        OVF <= 1'b1;
      end else if (CLROVF) begin
        OVF <= 1'b0;
      end
    end
  end

endmodule
